instr_deser: RTL and testbench
==============================

# instr_deser

Byte-wide instruction deserializer between the xtal CPU byte interface and the request queue. Assembles an opcode byte plus MSB-first address bytes into one complete instruction. AES instructions carry key, text and dest addresses; SHA instructions carry text and dest only. Presents the instruction to the queue with a valid/ready handshake whose ready is selected by opcode, and holds it until accepted.

## Interface
Parameters:
- ADDRW, 24: address width; must be a multiple of 8; NB = ADDRW/8 bytes per address.
- OPCODEW, 2: opcode width; must be ≤ 8.
- TIMEOUT, 255: idle-cycle limit for a partial instruction; used only with DESER_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  CPU byte valid.
- in_data  in  8  CPU byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- valid_out  out  1  complete instruction present; drives queue valid_in.
- ready_in_aes  in  1  queue AES ready (ready_out_aes).
- ready_in_sha  in  1  queue SHA ready (ready_out_sha).
- opcode  out  OPCODEW  captured opcode.
- key_addr  out  ADDRW  captured key address; zero for SHA.
- text_addr  out  ADDRW  captured text address.
- dest_addr  out  ADDRW  captured dest address.
- err_timeout  out  1  one-cycle pulse when a partial instruction is discarded.

## Operation
- States: IDLE, KEY, TEXT, DEST, HOLD. Byte index counter bidx, 0..NB-1, shared by KEY, TEXT and DEST.
- IDLE: on accept, opcode <= in_data[OPCODEW-1:0]; upper bits are ignored; key_addr <= 0; bidx <= 0.
  - Next state is KEY if in_data[0]==0 (AES); otherwise TEXT (SHA).
- KEY/TEXT/DEST: each accepted byte shifts into the LSB of the field (field <= {field[ADDRW-9:0], in_data}).
  - bidx increments per byte.
  - On byte NB-1: bidx <= 0, advance KEY→TEXT, TEXT→DEST, DEST→HOLD.
- Cycles with in_valid=0 do not change state or fields.
- HOLD: valid_out=1 and all instruction outputs stable. The selected ready is ready_in_aes if opcode[0]==0, else ready_in_sha.
  - Selected ready high: transfer completes that edge and the next state is IDLE.
  - Otherwise stay in HOLD.
  - The non-selected ready is ignored.
- in_ready = rst_n && (state != HOLD).
- valid_out = (state == HOLD).
- Fields are not cleared after a transfer; only key_addr is zeroed at the next opcode capture.
- Reset (rst_n low at an edge): state IDLE, bidx 0, all fields/opcode 0, err_timeout 0; any partial or held instruction is dropped.
  - Reset values: valid_out 0; in_ready 0 while rst_n is low, 1 after release.

## Timing
- valid_out rises the cycle after the last dest byte is accepted.
- valid_out falls the cycle after the edge with valid_out && selected ready.
- Minimum instruction period with no stalls: AES 1+3NB+1 = 11 cycles; SHA 1+2NB+1 = 8 cycles (NB=3).
- No combinational path from ready_in_* or in_valid to any output except in_ready's dependence on rst_n.
- Queue backpressure of any length holds HOLD with in_ready=0. No byte is lost; the CPU stalls.

## Configuration
- DESER_TIMEOUT_EN defined:
  - An idle counter runs only in KEY/TEXT/DEST. It clears on each accepted byte and on state entry, and increments on every other cycle.
  - On reaching TIMEOUT: state <= IDLE, bidx <= 0, err_timeout pulses high for exactly one cycle (the cycle after the abort edge). Captured fields are left as is; key_addr is zeroed at the next opcode.
  - A byte accepted on the same cycle the count reaches TIMEOUT wins: no abort.
- DESER_TIMEOUT_EN undefined: no counter; err_timeout tied 0; a partial instruction waits forever.

## Structure
- Shared package ctrl_pkg holds:
  - state encodings (IDLE..HOLD);
  - OPC_SHA_BIT = 0 (routing bit);
  - default ADDRW/OPCODEW;
  - derived byte counts.
- Sub-module deser_timeout (idle counter + pulse generator, parameter TIMEOUT) is instantiated only under DESER_TIMEOUT_EN.

## Test plan
- AES with ADDRW=24, no stalls:
  - Stimulus: bytes 00 12 34 56 AB CD EF 00 01 00, ready_in_aes=1.
  - Required: valid_out high one cycle; opcode=0, key=0x123456, text=0xABCDEF, dest=0x000100.
- SHA with prior key 0x123456:
  - Stimulus: bytes 03 11 22 33 44 55 66.
  - Required: opcode=3, key=0, text=0x112233, dest=0x445566; transfer completes on ready_in_sha only, and ready_in_aes=1 alone does not complete it.
- Backpressure:
  - Stimulus: ready_in_aes low 5 cycles after AES completes.
  - Required: valid_out and fields stable, in_ready=0 throughout; release at cycle 6; a following byte is accepted the cycle after.
- Byte gaps:
  - Stimulus: in_valid toggled 1/0 through an AES instruction.
  - Required: identical captured values; valid_out delayed by the gap count.
- Timeout (DESER_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: 00 12, then 4 idle cycles.
  - Required: err_timeout one-cycle pulse; next byte 01 is treated as an opcode.
- Reset mid-instruction:
  - Stimulus: rst_n low for one edge after 5 bytes.
  - Required: IDLE, all outputs 0; a fresh full instruction decodes correctly.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction deserializer: state encodings,
// the opcode routing bit, default widths and derived byte counts.
package ctrl_pkg;

    localparam int DEF_ADDRW   = 24;
    localparam int DEF_OPCODEW = 2;
    localparam int DEF_TIMEOUT = 255;

    // Opcode bit that selects SHA (1) versus AES (0) routing.
    localparam int OPC_SHA_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_TEXT = 3'd2,
        ST_DEST = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Number of bytes carried by one address of the given width.
    function automatic int addr_bytes(input int addrw);
        return addrw / 8;
    endfunction

    localparam int DEF_NB        = addr_bytes(DEF_ADDRW);
    localparam int DEF_AES_BYTES = 1 + 3 * DEF_NB;
    localparam int DEF_SHA_BYTES = 1 + 2 * DEF_NB;

endpackage

// File: rtl/deser_timeout.sv
// Idle watchdog for a partially received instruction. Counts cycles without
// an accepted byte while the deserializer is collecting address bytes and
// requests an abort when the limit is reached; the error pulse follows the
// abort edge by one cycle. Only instantiated when DESER_TIMEOUT_EN is defined.
module deser_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic byte_taken,
    output logic abort,
    output logic err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;

    // An accepted byte on the limit cycle takes priority over the abort.
    assign abort = active && !byte_taken && (idle_cnt == CW'(TIMEOUT - 1));

    // Idle counter: cleared outside the collecting states, on every byte and on abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!active || byte_taken || abort) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // Single-cycle error pulse registered from the abort decision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
        end
    end

endmodule

// File: rtl/instr_deser.sv
// Byte-wide instruction deserializer. Collects an opcode byte followed by
// MSB-first key/text/dest address bytes (key only for AES), then holds the
// complete instruction with valid_out until the opcode-selected queue ready
// accepts it. Optional idle timeout enabled by defining DESER_TIMEOUT_EN.
module instr_deser
    import ctrl_pkg::*;
#(
    parameter int ADDRW   = DEF_ADDRW,
    parameter int OPCODEW = DEF_OPCODEW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               valid_out,
    input  logic               ready_in_aes,
    input  logic               ready_in_sha,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic [ADDRW-1:0]   dest_addr,
    output logic               err_timeout
);

    localparam int NB = addr_bytes(ADDRW);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    if ((ADDRW % 8) != 0 || ADDRW < 8 || OPCODEW < 1 || OPCODEW > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("instr_deser: illegal parameter combination");
    end

    state_t            state;
    state_t            state_next;
    logic [BW-1:0]     bidx;
    logic              accept;
    logic              last_byte;
    logic              sel_ready;
    logic              in_field;
    logic              abort;
    logic [ADDRW-1:0]  byte_ext;

    assign in_ready  = rst_n && (state != ST_HOLD);
    assign valid_out = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign in_field  = (state == ST_KEY) || (state == ST_TEXT) || (state == ST_DEST);
    assign last_byte = (bidx == LAST_IDX);
    assign sel_ready = opcode[OPC_SHA_BIT] ? ready_in_sha : ready_in_aes;
    assign byte_ext  = ADDRW'(in_data);

`ifdef DESER_TIMEOUT_EN
    deser_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (in_field),
        .byte_taken  (accept),
        .abort       (abort),
        .err_timeout (err_timeout)
    );
`else
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: advance per address field, wait in HOLD for the routed ready.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = in_data[OPC_SHA_BIT] ? ST_TEXT : ST_KEY;
            ST_KEY:  if (accept && last_byte) state_next = ST_TEXT;
            ST_TEXT: if (accept && last_byte) state_next = ST_DEST;
            ST_DEST: if (accept && last_byte) state_next = ST_HOLD;
            ST_HOLD: if (sel_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // Field capture: opcode byte starts a new instruction, address bytes shift in MSB-first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode    <= '0;
            key_addr  <= '0;
            text_addr <= '0;
            dest_addr <= '0;
            bidx      <= '0;
        end else if (state == ST_IDLE && accept) begin
            opcode   <= in_data[OPCODEW-1:0];
            key_addr <= '0;
            bidx     <= '0;
        end else if (abort) begin
            bidx <= '0;
        end else if (in_field && accept) begin
            case (state)
                ST_KEY:  key_addr  <= (key_addr  << 8) | byte_ext;
                ST_TEXT: text_addr <= (text_addr << 8) | byte_ext;
                default: dest_addr <= (dest_addr << 8) | byte_ext;
            endcase
            bidx <= last_byte ? '0 : bidx + BW'(1);
        end
    end

endmodule

// File: tb/tb_instr_deser.sv
// Self-checking bench for instr_deser: table vectors, hand-written multi-cycle
// sequences and randomized instructions checked against a byte-stream decoder.
module tb_instr_deser;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        valid_out;
    logic        ready_in_aes;
    logic        ready_in_sha;
    logic [1:0]  opcode;
    logic [23:0] key_addr;
    logic [23:0] text_addr;
    logic [23:0] dest_addr;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int errPulses = 0;

    instr_deser #(
        .ADDRW   (24),
        .OPCODEW (2),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .valid_out    (valid_out),
        .ready_in_aes (ready_in_aes),
        .ready_in_sha (ready_in_sha),
        .opcode       (opcode),
        .key_addr     (key_addr),
        .text_addr    (text_addr),
        .dest_addr    (dest_addr),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Count error pulses sampled mid-cycle.
    always @(negedge clk) if (err_timeout === 1'b1) errPulses <= errPulses + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct packed {
        logic [79:0] stream;
        logic [3:0]  nbytes;
        logic        pre_ready;
        logic        gaps;
        logic [1:0]  opc;
        logic [23:0] key;
        logic [23:0] text;
        logic [23:0] dest;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic idleCycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("byte_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [79:0] stream, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            sendByte(stream[79 - 8*i -: 8]);
            if (gaps && i != n - 1) idleCycles(1);
        end
    endtask

    task automatic checkInstr(input logic [1:0] e_opc, input logic [23:0] e_key,
                              input logic [23:0] e_text, input logic [23:0] e_dest);
        checkOutput("valid_out", 32'(valid_out), 32'd1);
        checkOutput("opcode", 32'(opcode), 32'(e_opc));
        checkOutput("key_addr", 32'(key_addr), 32'(e_key));
        checkOutput("text_addr", 32'(text_addr), 32'(e_text));
        checkOutput("dest_addr", 32'(dest_addr), 32'(e_dest));
    endtask

    task automatic releaseInstr(input bit sha);
        if (sha) ready_in_sha = 1'b1;
        else     ready_in_aes = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("valid_fall", 32'(valid_out), 32'd0);
        checkOutput("in_ready_after", 32'(in_ready), 32'd1);
        ready_in_aes = 1'b0;
        ready_in_sha = 1'b0;
    endtask

    // Reference decoder: interpret a byte stream as opcode plus 3-byte big-endian addresses.
    function automatic int addrAt(input logic [79:0] s, input int p);
        return int'(s[79 - 8*p -: 8]) * 65536 + int'(s[79 - 8*(p+1) -: 8]) * 256
               + int'(s[79 - 8*(p+2) -: 8]);
    endfunction

    task automatic modelDecode(input logic [79:0] s, output int nb, output logic [1:0] opc,
                               output logic [23:0] key, output logic [23:0] text,
                               output logic [23:0] dest);
        int op;
        bit aes;
        op  = int'(s[79:72]);
        aes = (op % 2 == 0);
        opc = 2'(op % 4);
        nb  = aes ? DEF_AES_BYTES : DEF_SHA_BYTES;
        key  = aes ? 24'(addrAt(s, 1)) : 24'd0;
        text = 24'(addrAt(s, aes ? 4 : 1));
        dest = 24'(addrAt(s, aes ? 7 : 4));
    endtask

    initial begin
        vec_t v;
        int start;
        int n;
        int expLat;
        logic [79:0] rs;
        logic [1:0]  mOpc;
        logic [23:0] mKey, mText, mDest;
        int mN;

        vecs[0] = '{stream:80'h00_123456_ABCDEF_000100, nbytes:4'd10, pre_ready:1'b1, gaps:1'b0,
                    opc:2'd0, key:24'h123456, text:24'hABCDEF, dest:24'h000100};
        vecs[1] = '{stream:80'h03_112233_445566_000000, nbytes:4'd7, pre_ready:1'b0, gaps:1'b0,
                    opc:2'd3, key:24'h000000, text:24'h112233, dest:24'h445566};
        vecs[2] = '{stream:80'h00_123456_ABCDEF_000100, nbytes:4'd10, pre_ready:1'b0, gaps:1'b1,
                    opc:2'd0, key:24'h123456, text:24'hABCDEF, dest:24'h000100};
        vecs[3] = '{stream:80'hFD_010203_A0B0C0_000000, nbytes:4'd7, pre_ready:1'b0, gaps:1'b1,
                    opc:2'd1, key:24'h000000, text:24'h010203, dest:24'hA0B0C0};
        vecs[4] = '{stream:80'h06_FFFFFF_000000_800001, nbytes:4'd10, pre_ready:1'b0, gaps:1'b0,
                    opc:2'd2, key:24'hFFFFFF, text:24'h000000, dest:24'h800001};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        ready_in_aes = 1'b0;
        ready_in_sha = 1'b0;
        idleCycles(2);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_valid", 32'(valid_out), 32'd0);
        checkOutput("reset_opcode", 32'(opcode), 32'd0);
        checkOutput("reset_key", 32'(key_addr), 32'd0);
        checkOutput("reset_err", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] table vectors");
        for (int t = 0; t < NV; t++) begin
            v = vecs[t];
            n = int'(v.nbytes);
            if (v.pre_ready) begin
                if (v.opc[OPC_SHA_BIT]) ready_in_sha = 1'b1;
                else                    ready_in_aes = 1'b1;
            end
            start = cyc;
            applyStimulus(v.stream, n, v.gaps);
            expLat = v.gaps ? (2*n - 1) : n;
            checkOutput("latency", 32'(cyc - start), 32'(expLat));
            checkInstr(v.opc, v.key, v.text, v.dest);
            if (!v.pre_ready) begin
                if (v.opc[OPC_SHA_BIT]) ready_in_aes = 1'b1;
                else                    ready_in_sha = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    checkOutput("hold_nonsel", 32'(valid_out), 32'd1);
                end
                ready_in_aes = 1'b0;
                ready_in_sha = 1'b0;
                if (v.opc[OPC_SHA_BIT]) ready_in_sha = 1'b1;
                else                    ready_in_aes = 1'b1;
            end
            @(posedge clk);
            #1;
            checkOutput("valid_fall", 32'(valid_out), 32'd0);
            ready_in_aes = 1'b0;
            ready_in_sha = 1'b0;
        end

        $display("[TB] backpressure");
        applyStimulus(80'h00_A1A2A3_B1B2B3_C1C2C3, 10, 1'b0);
        checkInstr(2'd0, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3);
        in_valid = 1'b1;
        in_data = 8'h00;
        ready_in_sha = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 32'(valid_out), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_text", 32'(text_addr), 32'h00B1B2B3);
        end
        ready_in_sha = 1'b0;
        ready_in_aes = 1'b1;
        @(posedge clk);
        #1;
        ready_in_aes = 1'b0;
        checkOutput("bp_release_valid", 32'(valid_out), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(80'h00_010203_040506_070809, 10, 1'b0);
        checkInstr(2'd0, 24'h010203, 24'h040506, 24'h070809);
        releaseInstr(1'b0);

        $display("[TB] reset mid-instruction");
        applyStimulus(80'h00_111111_222222_333333, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);
        checkOutput("rst_key", 32'(key_addr), 32'd0);
        checkOutput("rst_text", 32'(text_addr), 32'd0);
        checkOutput("rst_dest", 32'(dest_addr), 32'd0);
        checkOutput("rst_in_ready_rel", 32'(in_ready), 32'd1);
        applyStimulus(80'h02_0A0B0C_1A1B1C_2A2B2C, 10, 1'b0);
        checkInstr(2'd2, 24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C);
        releaseInstr(1'b0);

`ifdef DESER_TIMEOUT_EN
        $display("[TB] timeout abort");
        applyStimulus(80'h0012_0000_0000_0000_0000, 2, 1'b0);
        idleCycles(3);
        checkOutput("to_err_early", 32'(err_timeout), 32'd0);
        idleCycles(1);
        checkOutput("to_err_pulse", 32'(err_timeout), 32'd1);
        checkOutput("to_in_ready", 32'(in_ready), 32'd1);
        idleCycles(1);
        checkOutput("to_err_end", 32'(err_timeout), 32'd0);
        applyStimulus(80'h01_AABBCC_DDEEFF_000000, 7, 1'b0);
        checkInstr(2'd1, 24'h000000, 24'hAABBCC, 24'hDDEEFF);
        releaseInstr(1'b1);
        $display("[TB] byte on the limit cycle");
        sendByte(8'h00);
        idleCycles(3);
        sendByte(8'h12);
        idleCycles(3);
        applyStimulus(80'h3456ABCDEF000100_0000, 8, 1'b0);
        checkInstr(2'd0, 24'h123456, 24'hABCDEF, 24'h000100);
        releaseInstr(1'b0);
`else
        $display("[TB] partial instruction waits");
        applyStimulus(80'h0012_0000_0000_0000_0000, 2, 1'b0);
        idleCycles(20);
        checkOutput("wait_valid", 32'(valid_out), 32'd0);
        checkOutput("wait_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(80'h3456ABCDEF000100_0000, 8, 1'b0);
        checkInstr(2'd0, 24'h123456, 24'hABCDEF, 24'h000100);
        releaseInstr(1'b0);
`endif

        $display("[TB] randomized instructions");
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 10; i++) rs[79 - 8*i -: 8] = 8'($urandom);
            modelDecode(rs, mN, mOpc, mKey, mText, mDest);
            for (int i = 0; i < mN; i++) begin
                sendByte(rs[79 - 8*i -: 8]);
                if (i != mN - 1) idleCycles($urandom_range(0, 2));
            end
            checkInstr(mOpc, mKey, mText, mDest);
            repeat ($urandom_range(0, 3)) begin
                if (mOpc[OPC_SHA_BIT]) ready_in_aes = 1'($urandom);
                else                   ready_in_sha = 1'($urandom);
                @(posedge clk);
                #1;
                checkOutput("rand_hold", 32'(valid_out), 32'd1);
            end
            ready_in_aes = 1'b0;
            ready_in_sha = 1'b0;
            releaseInstr(mOpc[OPC_SHA_BIT]);
        end

`ifdef DESER_TIMEOUT_EN
        checkOutput("err_pulses", 32'(errPulses), 32'd1);
`else
        checkOutput("err_pulses", 32'(errPulses), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
